// File: rtl/rns_mod5_sched.sv
// Round-robin front end that time-shares one external mod-5 fold reducer between
// NUM_REQ requesters and returns a true residue (0..4) tagged with the requester id.
module rns_mod5_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int N_W     = 16,
  parameter int RED_W   = 5,
  parameter int RED_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*N_W-1:0]   req_data,
  output logic [N_W-1:0]           red_n,
  input  logic [RED_W-1:0]         red_sum,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2:0]               res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds data stable while valid is high and ready is low.

  localparam int CNT_W = (RED_LAT > 0) ? $clog2(RED_LAT + 1) : 1;
  localparam logic [RED_W-1:0] K20 = RED_W'(20);
  localparam logic [RED_W-1:0] K10 = RED_W'(10);
  localparam logic [RED_W-1:0] K5  = RED_W'(5);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [N_W-1:0]     red_n_q, red_n_d;
  logic               res_valid_q, res_valid_d;
  logic [2:0]         res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;

  logic [N_W-1:0]     ops [NUM_REQ];
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] ready_int;
  logic [RED_W-1:0]   s1, s2, s3;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i] = req_data[i*N_W +: N_W];
  end

  // Search starts one past the last grant; ID_W arithmetic wraps NUM_REQ-1 -> 0.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant_q + ID_W'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Partial sum is at most 31, so three conditional subtractions always land in 0..4.
  always_comb begin
    s1 = (red_sum >= K20) ? red_sum - K20 : red_sum;
    s2 = (s1 >= K10) ? s1 - K10 : s1;
    s3 = (s2 >= K5) ? s2 - K5 : s2;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    red_n_d      = red_n_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    ready_int    = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ready_int[grant_id] = 1'b1;
          red_n_d      = ops[grant_id];
          res_id_d     = grant_id;
          last_grant_d = grant_id;
          wait_cnt_d   = CNT_W'(RED_LAT);
          state_d      = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end else begin
          res_data_d  = 3'(s3);
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      red_n_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      red_n_q      <= red_n_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
    end
  end

  // The grant is combinational from the reset-state registers, so gate it on rst_n too.
  assign req_ready = rst_n ? ready_int : '0;
  assign red_n     = red_n_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rns_mod5_sched.sv
// Directed bench for rns_mod5_sched: one instance with a combinational reducer, one with
// a two-stage pipelined reducer for the randomised residue/id scoreboard run.
module tb_rns_mod5_sched;

  localparam int NOPS = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  rv0, rr0, rv2, rr2;
  logic [63:0] rd0, rd2;
  logic [15:0] redn0, redn2;
  logic [4:0]  rsum0, rsum2;
  logic        resv0, resr0, resv2, resr2, busy0, busy2;
  logic [2:0]  resd0, resd2;
  logic [1:0]  resid0, resid2, st0, st2;
  logic        force_en;
  logic [4:0]  force_val;
  logic [4:0]  p1 = '0, p2 = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  rns_mod5_sched #(.RED_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_data(rd0),
    .red_n(redn0), .red_sum(rsum0), .res_valid(resv0), .res_ready(resr0),
    .res_data(resd0), .res_id(resid0), .busy(busy0), .dbg_state(st0));

  rns_mod5_sched #(.RED_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rr2), .req_data(rd2),
    .red_n(redn2), .red_sum(rsum2), .res_valid(resv2), .res_ready(resr2),
    .res_data(resd2), .res_id(resid2), .busy(busy2), .dbg_state(st2));

  // Nibble fold: 16 == 1 (mod 5), so summing nibbles twice preserves the residue, result <= 18.
  function automatic logic [4:0] fold5(input logic [15:0] n);
    logic [5:0] a;
    a = {2'b0, n[15:12]} + {2'b0, n[11:8]} + {2'b0, n[7:4]} + {2'b0, n[3:0]};
    return {3'b0, a[5:4]} + {1'b0, a[3:0]};
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int lg);
    for (int k = 1; k <= 4; k++) begin
      if (v[(lg + k) % 4]) return (lg + k) % 4;
    end
    return -1;
  endfunction

  always_comb rsum0 = force_en ? force_val : fold5(redn0);
  always @(posedge clk) begin
    p1 <= fold5(redn2);
    p2 <= p1;
  end
  assign rsum2 = p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one0(input int id, input logic [15:0] data, input int exp_res, input string tag);
    int n;
    rv0 = 4'(1 << id);
    rd0[id*16 +: 16] = data;
    resr0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rr0 == 4'b0 && n < 10);
    check({tag, "_rdy"}, rr0, 4'(1 << id));
    @(posedge clk);
    #1;
    rv0 = 4'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resv0 && n < 10);
    check({tag, "_valid"}, resv0, 1);
    check({tag, "_data"}, resd0, exp_res);
    check({tag, "_id"}, resid0, id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, last, gi, cyc, pushed, popped, lg_m, g;
    logic [4:0] e;
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{0, 2, 3, 1, 0};
    logic [3:0] exp_gm[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    int fv[13] = '{0, 4, 5, 9, 19, 20, 22, 23, 24, 25, 29, 30, 31};

    rst_n = 1'b0;
    rv0 = 4'b1111; rv2 = 4'b1111; rd0 = '0; rd2 = '0;
    resr0 = 1'b0; resr2 = 1'b0; force_en = 1'b0; force_val = '0;

    // reset state
    #12;
    check("rst_ready0", rr0, 0);
    check("rst_ready2", rr2, 0);
    check("rst_valid", resv0, 0);
    check("rst_data", resd0, 0);
    check("rst_id", resid0, 0);
    check("rst_redn", redn0, 0);
    check("rst_busy", busy0, 0);
    check("rst_state", st0, 0);
    rv0 = 4'b0; rv2 = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request, latency
    @(posedge clk); #1;
    rv0 = 4'b0010; rd0[31:16] = 16'd1234; resr0 = 1'b0;
    @(negedge clk);
    check("t1_rdy", rr0, 4'b0010);
    check("t1_idle", busy0, 0);
    @(posedge clk); #1;
    rv0 = 4'b0;
    @(negedge clk);
    check("t1_rdy_off", rr0, 0);
    check("t1_busy", busy0, 1);
    check("t1_redn", redn0, 1234);
    check("t1_early", resv0, 0);
    @(negedge clk);
    check("t1_valid", resv0, 1);
    check("t1_data", resd0, 4);
    check("t1_id", resid0, 1);
    resr0 = 1'b1;
    @(negedge clk);
    check("t1_done", resv0, 0);
    check("t1_idle2", busy0, 0);
    resr0 = 1'b0;

    // all valid: strict rotation, 3 cycles apart
    do_reset();
    rd0 = {16'd21, 16'd13, 16'd7, 16'd65535};
    rv0 = 4'b1111; resr0 = 1'b1;
    k = 0; last = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clk);
      if (resv0) begin
        check("t2_id", resid0, exp_id[k]);
        check("t2_data", resd0, exp_res[k]);
        if (k > 0) check("t2_spacing", c - last, 3);
        last = c;
        k++;
      end
    end
    check("t2_count", k, 5);
    rv0 = 4'b0;

    // back-pressure in RESULT
    do_reset();
    rv0 = 4'b0001; rd0[15:0] = 16'd7; resr0 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resv0 && k < 10);
    rv0 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", resv0, 1);
      check("t3_data", resd0, 2);
      check("t3_id", resid0, 0);
      check("t3_rdy", rr0, 0);
      check("t3_busy", busy0, 1);
      @(negedge clk);
    end
    resr0 = 1'b1;
    @(negedge clk);
    check("t3_release_valid", resv0, 0);
    check("t3_release_busy", busy0, 0);
    check("t3_next_grant", rr0, 4'b0010);
    rv0 = 4'b0;

    // req0 and req2 only
    do_reset();
    rv0 = 4'b0101; rd0 = '0; rd0[15:0] = 16'd5; rd0[47:32] = 16'd8; resr0 = 1'b1;
    gi = 0;
    for (int c = 0; c < 40 && gi < 4; c++) begin
      @(negedge clk);
      check("t4_odd_rdy", rr0 & 4'b1010, 0);
      if (rr0 != 4'b0) begin
        check("t4_grant", rr0, exp_gm[gi]);
        gi++;
      end
    end
    check("t4_count", gi, 4);
    rv0 = 4'b0;

    // reset during REDUCE
    do_reset();
    rv0 = 4'b1000; rd0[63:48] = 16'd9; resr0 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rr0 == 4'b0 && k < 10);
    @(posedge clk); #1;
    rv0 = 4'b1111;
    check("t5_in_reduce", busy0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_valid", resv0, 0);
    check("t5_rdy", rr0, 0);
    check("t5_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_first_grant", rr0, 4'b0001);
    rv0 = 4'b0;

    // out-of-spec and boundary partial sums through the cascade
    do_reset();
    force_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      force_val = 5'(fv[i]);
      run_one0(0, 16'd0, fv[i] % 5, "t7_fold");
    end
    force_en = 1'b0;

    // pipelined reducer, random operands/valids/res_ready
    do_reset();
    lg_m = 3; pushed = 0; popped = 0; cyc = 0;
    while (popped < NOPS && cyc < 40000) begin
      @(posedge clk); #1;
      rv2 = (pushed < NOPS) ? 4'($urandom_range(0, 15)) : 4'b0;
      for (int i = 0; i < 4; i++) rd2[i*16 +: 16] = 16'($urandom_range(0, 65535));
      resr2 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rr2 != 4'b0) begin
        g = rr_pick(rv2, lg_m);
        check("t6_grant", rr2, (g < 0) ? 4'b0 : 4'(1 << g));
        if (g >= 0) begin
          exp_q.push_back({2'(g), 3'(rd2[g*16 +: 16] % 16'd5)});
          lg_m = g;
        end
        pushed++;
      end
      if (resv2 && resr2) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious", resv2, 0);
        end else begin
          e = exp_q.pop_front();
          check("t6_id", resid2, e[4:3]);
          check("t6_res", resd2, e[2:0]);
        end
        popped++;
      end
      cyc++;
    end
    check("t6_count", popped, NOPS);
    rv2 = 4'b0; resr2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
